// File: rtl/cpu_run_controller.sv
// Run/reset sequencer for the single-cycle MIPS core: stretches reset, gates
// execution through cpu_en, and supports free-run, bounded-run and single-step.
module cpu_run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [CNT_W-1:0] run_len,
    input  logic             halt_req,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done
);

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        IDLE = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        HALT = 3'd4
    } state_t;

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

    state_t           cur, nxt;
    logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0] remaining, rem_nxt;
    logic [CNT_W-1:0] cnt_nxt, cnt_inc;

    // Saturating increment; remaining is tracked independently of saturation.
    assign cnt_inc = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

    always_comb begin
        nxt          = cur;
        hold_cnt_nxt = hold_cnt;
        rem_nxt      = remaining;
        cnt_nxt      = cycle_count;
        case (cur)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    nxt          = IDLE;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            IDLE, HALT: begin
                if (start) begin
                    nxt     = RUN;
                    rem_nxt = run_len;
                    cnt_nxt = '0;
                end else if (step) begin
                    nxt = STEP;
                end
            end
            RUN: begin
                cnt_nxt = cnt_inc;
                if (remaining != '0)
                    rem_nxt = remaining - 1'b1;
                // remaining==0 means free run: only halt_req ends it.
                if (halt_req || remaining == CNT_W'(1))
                    nxt = HALT;
            end
            STEP: begin
                cnt_nxt = cnt_inc;
                nxt     = halt_req ? HALT : IDLE;
            end
            default: begin
                nxt          = HOLD;
                hold_cnt_nxt = '0;
                rem_nxt      = '0;
                cnt_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= HOLD;
            hold_cnt    <= '0;
            remaining   <= '0;
            cycle_count <= '0;
        end else begin
            cur         <= nxt;
            hold_cnt    <= hold_cnt_nxt;
            remaining   <= rem_nxt;
            cycle_count <= cnt_nxt;
        end
    end

    assign state     = cur;
    assign cpu_reset = (cur == HOLD);
    assign cpu_en    = (cur == RUN) || (cur == STEP);
    assign done      = (cur == HALT);

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench: stimulus pushes expected outputs per cycle into a queue,
// a negedge monitor pops and compares against the DUTs.
module tb_cpu_run_controller;

    localparam logic [2:0] S_HOLD = 3'd0, S_IDLE = 3'd1, S_RUN = 3'd2,
                           S_STEP = 3'd3, S_HALT = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, step = 1'b0, halt_req = 1'b0;
    logic [31:0] run_len = '0;
    logic        cpu_reset, cpu_en, done;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    logic        rst_s = 1'b1, start_s = 1'b0, step_s = 1'b0, halt_s = 1'b0;
    logic [3:0]  len_s = '0;
    logic        cpu_reset_s, cpu_en_s, done_s;
    logic [2:0]  state_s;
    logic [3:0]  cycle_count_s;

    always #5 clk = ~clk;

    cpu_run_controller #(.RESET_CYCLES(2), .CNT_W(32)) u_main (
        .clk(clk), .reset(rst), .start(start), .step(step), .run_len(run_len),
        .halt_req(halt_req), .cpu_reset(cpu_reset), .cpu_en(cpu_en),
        .state(state), .cycle_count(cycle_count), .done(done)
    );

    cpu_run_controller #(.RESET_CYCLES(2), .CNT_W(4)) u_small (
        .clk(clk), .reset(rst_s), .start(start_s), .step(step_s), .run_len(len_s),
        .halt_req(halt_s), .cpu_reset(cpu_reset_s), .cpu_en(cpu_en_s),
        .state(state_s), .cycle_count(cycle_count_s), .done(done_s)
    );

    typedef struct {
        string       nm;
        bit          sel;
        logic [2:0]  st;
        logic        cr;
        logic        en;
        logic        dn;
        logic [31:0] cc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input bit sel, input logic [2:0] st,
                              input logic cr, input logic en, input logic dn,
                              input logic [31:0] cc);
        exp_t e;
        e.nm = nm; e.sel = sel; e.st = st; e.cr = cr; e.en = en; e.dn = dn; e.cc = cc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [2:0]  a_st;
            logic        a_cr, a_en, a_dn;
            logic [31:0] a_cc;
            e = q.pop_front();
            if (e.sel) begin
                a_st = state_s; a_cr = cpu_reset_s; a_en = cpu_en_s; a_dn = done_s;
                a_cc = {28'd0, cycle_count_s};
            end else begin
                a_st = state; a_cr = cpu_reset; a_en = cpu_en; a_dn = done;
                a_cc = cycle_count;
            end
            n_cmp++;
            if (a_st !== e.st || a_cr !== e.cr || a_en !== e.en || a_dn !== e.dn || a_cc !== e.cc) begin
                n_bad++;
                $display("FAIL %s: got st=%0d rst=%b en=%b done=%b cnt=%0d, want st=%0d rst=%b en=%b done=%b cnt=%0d",
                         e.nm, a_st, a_cr, a_en, a_dn, a_cc, e.st, e.cr, e.en, e.dn, e.cc);
            end
        end
    end

    initial begin
        // Reset high for three edges, then two stretched HOLD cycles.
        repeat (3) tick();
        expect_out("reset_hold", 0, S_HOLD, 1, 0, 0, 0);
        rst = 1'b0;
        tick(); expect_out("hold_stretch", 0, S_HOLD, 1, 0, 0, 0);
        tick(); expect_out("reach_idle", 0, S_IDLE, 0, 0, 0, 0);

        // Bounded run of 5.
        run_len = 32'd5; start = 1'b1;
        tick(); expect_out("run5_enter", 0, S_RUN, 0, 1, 0, 0);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); expect_out("run5_body", 0, S_RUN, 0, 1, 0, 32'(i));
        end
        tick(); expect_out("run5_halt", 0, S_HALT, 0, 0, 1, 5);

        // Three single steps from HALT, halt_req ignored while idle.
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick(); expect_out("step_exec", 0, S_STEP, 0, 1, 0, 32'(5 + k));
            step = 1'b0;
            tick(); expect_out("step_idle", 0, S_IDLE, 0, 0, 0, 32'(6 + k));
            halt_req = 1'b1;
            tick(); expect_out("idle_ign_halt", 0, S_IDLE, 0, 0, 0, 32'(6 + k));
            halt_req = 1'b0;
        end

        // start and step together: start wins, count cleared; free run halted on 8th cycle.
        run_len = 32'd0; start = 1'b1; step = 1'b1;
        tick(); expect_out("start_prio", 0, S_RUN, 0, 1, 0, 0);
        start = 1'b0; step = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick(); expect_out("free_body", 0, S_RUN, 0, 1, 0, 32'(i));
        end
        halt_req = 1'b1;
        tick(); expect_out("free_halt", 0, S_HALT, 0, 0, 1, 8);
        halt_req = 1'b0;

        // run_len=1 edge case.
        run_len = 32'd1; start = 1'b1;
        tick(); expect_out("run1_enter", 0, S_RUN, 0, 1, 0, 0);
        start = 1'b0;
        tick(); expect_out("run1_halt", 0, S_HALT, 0, 0, 1, 1);

        // Step with halt_req lands in HALT.
        step = 1'b1;
        tick(); expect_out("step_h_exec", 0, S_STEP, 0, 1, 0, 1);
        step = 1'b0; halt_req = 1'b1;
        tick(); expect_out("step_h_halt", 0, S_HALT, 0, 0, 1, 2);
        halt_req = 1'b0;

        // Reset after the 4th enabled cycle of a 10-cycle run.
        run_len = 32'd10; start = 1'b1;
        tick(); expect_out("run10_enter", 0, S_RUN, 0, 1, 0, 0);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(); expect_out("run10_body", 0, S_RUN, 0, 1, 0, 32'(i));
        end
        rst = 1'b1;
        tick(); expect_out("midrun_reset", 0, S_HOLD, 1, 0, 0, 0);
        rst = 1'b0;
        tick(); expect_out("rehold", 0, S_HOLD, 1, 0, 0, 0);
        tick(); expect_out("reidle", 0, S_IDLE, 0, 0, 0, 0);
        tick(); expect_out("reidle_stay", 0, S_IDLE, 0, 0, 0, 0);

        // Fresh run of 2 after reset: old run_len was discarded.
        run_len = 32'd2; start = 1'b1;
        tick(); expect_out("run2_enter", 0, S_RUN, 0, 1, 0, 0);
        start = 1'b0;
        tick(); expect_out("run2_body", 0, S_RUN, 0, 1, 0, 1);
        tick(); expect_out("run2_halt", 0, S_HALT, 0, 0, 1, 2);

        // 4-bit counter: free run of 20 cycles saturates at 15.
        tick(); expect_out("s_reset", 1, S_HOLD, 1, 0, 0, 0);
        rst_s = 1'b0;
        tick(); expect_out("s_hold", 1, S_HOLD, 1, 0, 0, 0);
        tick(); expect_out("s_idle", 1, S_IDLE, 0, 0, 0, 0);
        len_s = 4'd0; start_s = 1'b1;
        tick(); expect_out("s_enter", 1, S_RUN, 0, 1, 0, 0);
        start_s = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick(); expect_out("s_sat", 1, S_RUN, 0, 1, 0, (i > 15) ? 32'd15 : 32'(i));
        end
        halt_s = 1'b1;
        tick(); expect_out("s_halt", 1, S_HALT, 0, 0, 1, 15);
        halt_s = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
